seg_scan_ctrl: RTL and testbench

Scan controller for the 8-digit seven-segment display. Generates the digit-select code for the 8:1 nibble mux and the matching active-low anode pattern. Holds the 32-bit display word in a shadow register that is updated only at frame boundaries, so the display never tears. Sits between the datapath/register-file display source and the nibble mux/segment decoder.

---
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Scan controller for an 8-digit multiplexed seven-segment display.
// A prescaler produces one tick every TICK_DIV clocks. Each tick advances the
// digit select and the matching active-low anode pattern, which are updated
// together in the same register stage. The display word is double-buffered.
// Loads go into a pending register, and they are committed to D only on the
// 7->0 wrap tick, so a frame never shows a mix of two words.
//
// Parameters:
//   TICK_DIV  clocks per digit slot (>= 1)
//   CNT_W     prescaler width, must hold TICK_DIV-1
//
// Optional build macro:
//   SEG_SCAN_LZB_EN  leading-zero blanking. Digit k (k >= 1) goes dark when
//                    nibbles k..7 of the committed word are all zero.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   ld       in   load request, din captured while high
//   din      in   32-bit display word, nibble k = digit k
//   en_mask  in   per-digit enable, sampled on tick edges
//   D        out  committed display word (nibble mux data)
//   sel      out  digit select (nibble mux select)
//   an       out  active-low anodes, one-hot-low or all high
//   busy     out  a load is pending and not yet committed
//   ld_ack   out  one-cycle pulse when a pending load commits
//   frame    out  one-cycle pulse on each sel wrap 7->0
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned CNT_W    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic [31:0] din,
    input  logic [7:0]  en_mask,
    output logic [31:0] D,
    output logic [2:0]  sel,
    output logic [7:0]  an,
    output logic        busy,
    output logic        ld_ack,
    output logic        frame
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       sel_q,   sel_d;
    logic [7:0]       an_q,    an_d;
    logic [31:0]      disp_q,  disp_d;
    logic [31:0]      pend_q,  pend_d;
    logic             busy_q,  busy_d;
    logic             ack_q,   ack_d;
    logic             frame_q, frame_d;

    logic       tick;
    logic       wrap;
    logic       commit;
    logic [7:0] lit;    // digits allowed to light in their slot

    // NOTE: every combinational output gets a default at the top of the
    // block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        wrap    = tick && (sel_q == 3'd7);
        commit  = wrap && busy_q;

        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);

        // Commit takes the old pending word. A coincident ld refills the
        // pending register and keeps busy set for the next frame.
        disp_d  = commit ? pend_q : disp_q;
        pend_d  = ld ? din : pend_q;
        busy_d  = ld | (busy_q & ~commit);
        ack_d   = commit;
        frame_d = wrap;
    end

`ifdef SEG_SCAN_LZB_EN
    // Blanking looks at the word as it stands after this edge's commit,
    // so the first slot of a new frame already reflects the new word.
    always_comb begin
        logic upper_zero;
        lit        = en_mask;
        upper_zero = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            upper_zero = upper_zero & (disp_d[4*k +: 4] == 4'h0);
            if (upper_zero) begin
                lit[k] = 1'b0;
            end
        end
    end
`else
    assign lit = en_mask;
`endif

    // sel and an are computed from the same next value so that the two
    // registers always agree.
    always_comb begin
        sel_d = sel_q;
        an_d  = an_q;
        if (tick) begin
            sel_d = sel_q + 3'd1;
            an_d  = lit[sel_d] ? ~(8'd1 << sel_d) : 8'hFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            an_q    <= 8'hFF;
            disp_q  <= 32'd0;
            pend_q  <= 32'd0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            frame_q <= frame_d;
        end
    end

    assign D      = disp_q;
    assign sel    = sel_q;
    assign an     = an_q;
    assign busy   = busy_q;
    assign ld_ack = ack_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Drives two instances from one set of inputs. u0 uses TICK_DIV=4 and u1 uses
// TICK_DIV=1. A reference model computes slot position from an edge count
// and tracks the pending and committed words. One compare process checks
// every output of both instances on each falling edge. A directed phase pins
// the model with literal expectations, and a randomized phase follows it.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        ld;
    logic [31:0] din;
    logic [7:0]  en_mask;

    logic [31:0] d_w     [2];
    logic [2:0]  sel_w   [2];
    logic [7:0]  an_w    [2];
    logic        busy_w  [2];
    logic        ack_w   [2];
    logic        frame_w [2];

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 0;

    seg_scan_ctrl #(.TICK_DIV(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .ld(ld), .din(din), .en_mask(en_mask),
        .D(d_w[0]), .sel(sel_w[0]), .an(an_w[0]), .busy(busy_w[0]),
        .ld_ack(ack_w[0]), .frame(frame_w[0])
    );

    seg_scan_ctrl #(.TICK_DIV(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .reset(reset), .ld(ld), .din(din), .en_mask(en_mask),
        .D(d_w[1]), .sel(sel_w[1]), .an(an_w[1]), .busy(busy_w[1]),
        .ld_ack(ack_w[1]), .frame(frame_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------ model
    int          td      [2] = '{4, 1};
    int          edges   [2];
    logic [2:0]  m_sel   [2];
    logic [7:0]  m_an    [2];
    logic [31:0] m_d     [2];
    logic [31:0] m_pend  [2];
    logic        m_busy  [2];
    logic        m_ack   [2];
    logic        m_frame [2];

    function automatic bit digit_lit(int k, logic [7:0] mask, logic [31:0] word);
        bit r;
        r = mask[k];
`ifdef SEG_SCAN_LZB_EN
        if (k >= 1 && (word >> (4 * k)) == 32'd0) r = 1'b0;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit tk;
        int ticks;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                edges[i] = 0;   m_sel[i] = 3'd0;  m_an[i] = 8'hFF;
                m_d[i] = 32'd0; m_pend[i] = 32'd0;
                m_busy[i] = 1'b0; m_ack[i] = 1'b0; m_frame[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                tk = (edges[i] % td[i]) == td[i] - 1;
                edges[i]++;
                m_ack[i]   = 1'b0;
                m_frame[i] = 1'b0;
                if (tk) begin
                    ticks    = edges[i] / td[i];
                    m_sel[i] = 3'(ticks % 8);
                    if (m_sel[i] == 3'd0) begin
                        m_frame[i] = 1'b1;
                        if (m_busy[i]) begin
                            m_d[i]    = m_pend[i];
                            m_busy[i] = 1'b0;
                            m_ack[i]  = 1'b1;
                        end
                    end
                    m_an[i] = digit_lit(int'(m_sel[i]), en_mask, m_d[i])
                              ? ~(8'd1 << m_sel[i]) : 8'hFF;
                end
                if (ld) begin
                    m_pend[i] = din;
                    m_busy[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d.sel", i),    32'(sel_w[i]),   32'(m_sel[i]));
                check($sformatf("u%0d.an", i),     32'(an_w[i]),    32'(m_an[i]));
                check($sformatf("u%0d.D", i),      d_w[i],          m_d[i]);
                check($sformatf("u%0d.busy", i),   32'(busy_w[i]),  32'(m_busy[i]));
                check($sformatf("u%0d.ld_ack", i), 32'(ack_w[i]),   32'(m_ack[i]));
                check($sformatf("u%0d.frame", i),  32'(frame_w[i]), 32'(m_frame[i]));
            end
        end
    end

    // ------------------------------------------------------------ helpers
    // Wait for u0's sel to change, bounded.
    task automatic wait_change(output bit ok);
        logic [2:0] s0;
        s0 = sel_w[0];
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (sel_w[0] !== s0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL scan_timeout: sel stuck at %0d", s0);
        end
    endtask

    // Wait until u0's sel steps into target.
    task automatic wait_sel(input logic [2:0] target);
        bit ok;
        for (int t = 0; t < 9; t++) begin
            wait_change(ok);
            if (!ok) return;
            if (sel_w[0] == target) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL sel_timeout: never reached %0d", target);
    endtask

    task automatic pulse_ld(input logic [31:0] w);
        ld  = 1'b1;
        din = w;
        @(negedge clk);
        ld  = 1'b0;
    endtask

    // Called just after a wrap, with sel=0. It walks one full frame and checks
    // sel, an, and frame against literals. exp holds an for slot k in byte k.
    task automatic scan_check(input string name, input logic [63:0] exp);
        bit ok;
        int s;
        for (int i = 1; i <= 8; i++) begin
            wait_change(ok);
            s = i % 8;
            check({name, ".sel"},   32'(sel_w[0]),   32'(s));
            check({name, ".an"},    32'(an_w[0]),    32'(exp[8*s +: 8]));
            check({name, ".frame"}, 32'(frame_w[0]), 32'(i == 8));
        end
    endtask

    localparam logic [63:0] ALL_LIT = 64'h7FBF_DFEF_F7FB_FDFE;
`ifdef SEG_SCAN_LZB_EN
    localparam logic [63:0] EXP_ZERO = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] EXP_A0   = 64'hFFFF_FFFF_FFFF_FDFE;
`else
    localparam logic [63:0] EXP_ZERO = ALL_LIT;
    localparam logic [63:0] EXP_A0   = ALL_LIT;
`endif

    // ------------------------------------------------------------ stimulus
    initial begin
        reset   = 1'b0;
        ld      = 1'b0;
        din     = 32'd0;
        en_mask = 8'hFF;
        run     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.sel", 32'(sel_w[0]), 32'd0);
        check("rst.an",  32'(an_w[0]),  32'hFF);
        reset = 1'b1;
        check("rel.D",    d_w[0],          32'd0);
        check("rel.busy", 32'(busy_w[0]),  32'd0);
        check("rel.sel",  32'(sel_w[0]),   32'd0);
        check("rel.an",   32'(an_w[0]),    32'hFF);

        // Scan sequence from reset. D=0 means only digit 0 survives blanking.
        scan_check("scan", EXP_ZERO);

        // Frame-aligned load.
        wait_sel(3'd2);
        pulse_ld(32'h1234_5678);
        check("load.busy", 32'(busy_w[0]), 32'd1);
        check("load.D",    d_w[0],         32'd0);
        wait_sel(3'd7);
        check("load.D7",   d_w[0],         32'd0);
        wait_sel(3'd0);
        check("commit.D",    d_w[0],         32'h1234_5678);
        check("commit.ack",  32'(ack_w[0]),  32'd1);
        check("commit.busy", 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        check("commit.ack_clr", 32'(ack_w[0]), 32'd0);

        // Last write wins.
        wait_sel(3'd1);
        pulse_ld(32'hAAAA_0000);
        wait_sel(3'd3);
        pulse_ld(32'h0000_BBBB);
        wait_sel(3'd7);
        check("lw.D_hold", d_w[0], 32'h1234_5678);
        wait_sel(3'd0);
        check("lw.D",   d_w[0],        32'h0000_BBBB);
        check("lw.ack", 32'(ack_w[0]), 32'd1);

        // Coincident ld and commit. The wrap tick lands 4 clocks after sel=7.
        wait_sel(3'd4);
        pulse_ld(32'h1111_1111);
        wait_sel(3'd7);
        repeat (3) @(negedge clk);
        pulse_ld(32'h2222_2222);
        check("co.sel",  32'(sel_w[0]),  32'd0);
        check("co.D",    d_w[0],         32'h1111_1111);
        check("co.ack",  32'(ack_w[0]),  32'd1);
        check("co.busy", 32'(busy_w[0]), 32'd1);
        wait_sel(3'd7);
        wait_sel(3'd0);
        check("co2.D",    d_w[0],         32'h2222_2222);
        check("co2.ack",  32'(ack_w[0]),  32'd1);
        check("co2.busy", 32'(busy_w[0]), 32'd0);

        // Mask: only digits 0 and 2 are enabled.
        en_mask = 8'b0000_0101;
        scan_check("mask", 64'hFFFF_FFFF_FFFB_FFFE);

        // Leading-zero cases, which are all lit when blanking is compiled out.
        en_mask = 8'hFF;
        pulse_ld(32'h0000_00A0);
        wait_sel(3'd0);
        check("lzb.D_a0", d_w[0], 32'h0000_00A0);
        scan_check("lzb_a0", EXP_A0);
        pulse_ld(32'h0000_0000);
        wait_sel(3'd0);
        check("lzb.D_0", d_w[0], 32'd0);
        scan_check("lzb_0", EXP_ZERO);

        // Reset during a pending load discards it.
        pulse_ld(32'hCAFE_F00D);
        wait_sel(3'd0);
        check("pre.D", d_w[0], 32'hCAFE_F00D);
        pulse_ld(32'hDEAD_BEEF);
        check("mid.busy", 32'(busy_w[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid.busy_rst", 32'(busy_w[0]), 32'd0);
        check("mid.D_rst",    d_w[0],         32'd0);
        check("mid.an_rst",   32'(an_w[0]),   32'hFF);
        @(negedge clk);
        reset = 1'b1;
        wait_sel(3'd0);
        check("mid.D_after",    d_w[0],         32'd0);
        check("mid.busy_after", 32'(busy_w[0]), 32'd0);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ld  = ($urandom_range(0, 5) == 0);
            din = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 63) == 0) en_mask = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        ld  = 1'b0;
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
